// File: rtl/if_pkg.sv
// Shared widths, FSM encoding and buffer depth for the instruction fetch stage.
// Build with IF_PREFETCH_EN defined for a 2-entry prefetch buffer (1 entry otherwise).
`ifndef IF_DEFINES_SV
`define IF_DEFINES_SV
`define IF_ADDR_W 32
`define IF_INST_W 32
`endif

package if_pkg;

  localparam int unsigned ADDR_W = `IF_ADDR_W;
  localparam int unsigned INST_W = `IF_INST_W;

`ifdef IF_PREFETCH_EN
  localparam int unsigned BUF_DEPTH = 2;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } if_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// In-order {pc,inst} buffer of BUF_DEPTH (1 or 2) entries; head reads 0 when empty.
// A push into a full buffer is accepted only when the head is popped in the same cycle.
module if_fifo
  import if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  if_entry_t  din,
  output logic       full,
  output logic       empty,
  output logic [1:0] count,
  output if_entry_t  head
);

  if_entry_t slot0;
  if_entry_t slot1;
  logic      do_push;
  logic      do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : slot0;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count <= '0;
    end else begin
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // slot0 is always the head: a pop shifts slot1 forward, a push fills the first free slot
  always_ff @(posedge clk) begin
    if (do_pop && do_push) begin
      if (count == 2'd1) begin
        slot0 <= din;
      end else begin
        slot0 <= slot1;
        slot1 <= din;
      end
    end else if (do_pop) begin
      slot0 <= slot1;
    end else if (do_push) begin
      if (empty) begin
        slot0 <= din;
      end else begin
        slot1 <= din;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: request FSM (IDLE/REQ/DISCARD) feeding an in-order buffer.
// IF_PREFETCH_EN selects the 2-entry prefetch buffer; default build holds one entry.
module if_stage
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
);

  if_state_t         state_q;
  if_state_t         state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] redir_pc_q;
  logic [ADDR_W-1:0] redir_pc_d;
  logic              consume;
  logic              redirect;
  logic              slot_free;
  logic              room_after_ack;
  logic              buf_full;
  logic              buf_empty;
  logic              buf_push;
  logic [1:0]        buf_count;
  if_entry_t         buf_din;
  if_entry_t         buf_head;

  assign if_valid       = !buf_empty;
  assign if_pc          = buf_head.pc;
  assign if_inst        = buf_head.inst;
  assign consume        = if_valid && !stall;
  assign redirect       = br && consume;
  assign slot_free      = !buf_full || consume;
  // After pushing the acked word, another slot remains if the head leaves or one was spare
  assign room_after_ack = consume || ((buf_count + 2'd1) < 2'(BUF_DEPTH));
  assign buf_din        = '{pc: fetch_pc_q, inst: mem_rdata};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    mem_req    = 1'b0;
    mem_addr   = '0;
    buf_push   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = word_align(br_addr);
          state_d    = S_REQ;
        end else if (slot_free) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc_q;
        if (redirect) begin
          // Without an ack the old request must complete first; its data is then dropped
          if (mem_ack) begin
            fetch_pc_d = word_align(br_addr);
          end else begin
            redir_pc_d = word_align(br_addr);
            state_d    = S_DISCARD;
          end
        end else if (mem_ack) begin
          buf_push   = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          if (!room_after_ack) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc_q;
        if (mem_ack) begin
          fetch_pc_d = redir_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  if_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (consume),
    .flush (redirect),
    .din   (buf_din),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count),
    .head  (buf_head)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns inst = addr + 0x1000_0000.
// Follows the 2-entry sequence when IF_PREFETCH_EN is defined, the 1-entry one otherwise.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] br_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br        (br),
    .br_addr   (br_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

  assign mem_rdata = mem_addr + 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc);
    logic [31:0] e_inst;
    e_inst = e_valid ? e_pc + 32'h1000_0000 : 32'h0;
    checks++;
    assert (mem_req === e_req) else begin
      errors++;
      $error("FAIL %s.mem_req observed=%0b expected=%0b", tag, mem_req, e_req);
    end
    checks++;
    assert (mem_addr === e_addr) else begin
      errors++;
      $error("FAIL %s.mem_addr observed=%h expected=%h", tag, mem_addr, e_addr);
    end
    checks++;
    assert (if_valid === e_valid) else begin
      errors++;
      $error("FAIL %s.if_valid observed=%0b expected=%0b", tag, if_valid, e_valid);
    end
    checks++;
    assert (if_pc === e_pc) else begin
      errors++;
      $error("FAIL %s.if_pc observed=%h expected=%h", tag, if_pc, e_pc);
    end
    checks++;
    assert (if_inst === e_inst) else begin
      errors++;
      $error("FAIL %s.if_inst observed=%h expected=%h", tag, if_inst, e_inst);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; br = 1'b0; br_addr = 32'h0; mem_ack = 1'b1;
    tick();
    tick();
    chk("reset", 1'b0, 32'h0, 1'b0, 32'h0);

`ifdef IF_PREFETCH_EN
    // stall held from reset release: two words buffered, then fetch stops
    rst = 1'b1; stall = 1'b1;
    chk("c0_idle", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk("c1_req0", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); chk("c2_req4", 1'b1, 32'h4, 1'b1, 32'h0);
    tick(); chk("c3_full", 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); chk("c4_full", 1'b0, 32'h0, 1'b1, 32'h0);
    stall = 1'b0;
    tick(); chk("c5_resume8", 1'b1, 32'h8, 1'b1, 32'h4);
    tick(); chk("c6_req12", 1'b1, 32'hC, 1'b1, 32'h8);
    // redirect while 0xC is outstanding and unacked
    mem_ack = 1'b0; stall = 1'b1;
    tick(); chk("c7_hold12", 1'b1, 32'hC, 1'b1, 32'h8);
    br = 1'b1; br_addr = 32'h100; stall = 1'b0;
    tick(); chk("c8_discard", 1'b1, 32'hC, 1'b0, 32'h0);
    br = 1'b0; mem_ack = 1'b1;
    tick(); chk("c9_req100", 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); chk("c10_pc100", 1'b1, 32'h104, 1'b1, 32'h100);
    // redirect coinciding with ack of 0x104
    br = 1'b1; br_addr = 32'h200;
    tick(); chk("c11_br_ack", 1'b1, 32'h200, 1'b0, 32'h0);
    br = 1'b0;
    tick(); chk("c12_pc200", 1'b1, 32'h204, 1'b1, 32'h200);
    // redirect under stall is ignored
    stall = 1'b1; br = 1'b1; br_addr = 32'h300;
    tick(); chk("c13_br_stall", 1'b0, 32'h0, 1'b1, 32'h200);
    br = 1'b0;
    tick(); chk("c14_intact", 1'b0, 32'h0, 1'b1, 32'h200);
    stall = 1'b0;
    tick(); chk("c15_pc204", 1'b1, 32'h208, 1'b1, 32'h204);
    // reset mid-request, with an ack during the reset cycle
    mem_ack = 1'b0;
    tick(); chk("c16_pending", 1'b1, 32'h208, 1'b0, 32'h0);
    rst = 1'b0; mem_ack = 1'b1;
    tick(); chk("c17_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    tick(); chk("c18_restart", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); chk("c19_req4", 1'b1, 32'h4, 1'b1, 32'h0);
    // address wrap from the top of memory
    br = 1'b1; br_addr = 32'hFFFF_FFFC;
    tick(); chk("c20_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    br = 1'b0;
    tick(); chk("c21_wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
`else
    // back-to-back acks: one-entry buffer alternates request and delivery
    rst = 1'b1; stall = 1'b0;
    chk("c0_idle", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk("c1_req0", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); chk("c2_pc0", 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); chk("c3_req4", 1'b1, 32'h4, 1'b0, 32'h0);
    tick(); chk("c4_pc4", 1'b0, 32'h0, 1'b1, 32'h4);
    tick(); chk("c5_req8", 1'b1, 32'h8, 1'b0, 32'h0);
    tick(); chk("c6_pc8", 1'b0, 32'h0, 1'b1, 32'h8);
    // stall holds the head and blocks new requests; redirect under stall is ignored
    stall = 1'b1;
    tick(); chk("c7_stall", 1'b0, 32'h0, 1'b1, 32'h8);
    br = 1'b1; br_addr = 32'h100;
    tick(); chk("c8_br_stall", 1'b0, 32'h0, 1'b1, 32'h8);
    // redirect from IDLE with a valid head
    stall = 1'b0;
    tick(); chk("c9_req100", 1'b1, 32'h100, 1'b0, 32'h0);
    br = 1'b0;
    tick(); chk("c10_pc100", 1'b0, 32'h0, 1'b1, 32'h100);
    tick(); chk("c11_req104", 1'b1, 32'h104, 1'b0, 32'h0);
    // unacked request holds, then reset with an ack in the reset cycle
    mem_ack = 1'b0;
    tick(); chk("c12_hold", 1'b1, 32'h104, 1'b0, 32'h0);
    rst = 1'b0; mem_ack = 1'b1;
    tick(); chk("c13_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    tick(); chk("c14_restart", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); chk("c15_pc0", 1'b0, 32'h0, 1'b1, 32'h0);
    // address wrap from the top of memory
    br = 1'b1; br_addr = 32'hFFFF_FFFC;
    tick(); chk("c16_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    br = 1'b0;
    tick(); chk("c17_pctop", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick(); chk("c18_wrap", 1'b1, 32'h0, 1'b0, 32'h0);
    // delayed ack: request stays stable, word appears the cycle after the ack
    mem_ack = 1'b0;
    tick(); chk("c19_wait", 1'b1, 32'h0, 1'b0, 32'h0);
    mem_ack = 1'b1;
    tick(); chk("c20_late", 1'b0, 32'h0, 1'b1, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
